// File: rtl/mac_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mac_seq
//  Description : Sequential fixed-point multiply-accumulate engine. Accepts a
//                vector length, consumes that many (ifmap, weight) operand
//                pairs over a valid/ready handshake, accumulates the trimmed
//                products with saturation and presents the dot product plus a
//                sticky saturation flag until the consumer accepts it.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_seq #(
  parameter int IFDATA_SIZE   = 8,   // unsigned fixed (8,7)
  parameter int WDATA_SIZE    = 8,   // signed fixed (8,6)
  parameter int MULT_OUT_SIZE = 8,   // signed fixed (8,5)
  parameter int ACC_SIZE      = 12,  // signed, 5 fraction bits
  parameter int LEN_SIZE      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [LEN_SIZE-1:0]      len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IFDATA_SIZE-1:0]   in_a,
  input  logic [WDATA_SIZE-1:0]    in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_SIZE-1:0]      out_data,
  output logic                     out_sat,
  output logic                     busy
);

  // Full product width: the true product of a zero-extended unsigned operand
  // and a signed operand always fits in IFDATA_SIZE+WDATA_SIZE signed bits,
  // so arithmetic modulo 2^PROD_W yields the exact two's-complement result.
  localparam int PROD_W = IFDATA_SIZE + WDATA_SIZE;
  localparam int TRIM_SHIFT = PROD_W - MULT_OUT_SIZE;

  localparam logic [ACC_SIZE-1:0] ACC_MAX = {1'b0, {(ACC_SIZE-1){1'b1}}};
  localparam logic [ACC_SIZE-1:0] ACC_MIN = {1'b1, {(ACC_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q;
  logic [LEN_SIZE-1:0]     cnt_q;
  logic [ACC_SIZE-1:0]     acc_q;
  logic                    sat_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    busy_q;

  logic [PROD_W-1:0]       w_a_ext;
  logic [PROD_W-1:0]       w_b_ext;
  logic [PROD_W-1:0]       w_prod_full;
  logic [MULT_OUT_SIZE-1:0] w_prod;
  logic [ACC_SIZE:0]       w_sum;
  logic                    w_ovf;
  logic [ACC_SIZE-1:0]     acc_d;
  logic                    sat_d;

  // Single-cycle multiply, trim to the product format, add with one guard
  // bit and clamp to the accumulator range.
  always_comb begin
    w_a_ext     = {{WDATA_SIZE{1'b0}}, in_a};
    w_b_ext     = {{IFDATA_SIZE{in_b[WDATA_SIZE-1]}}, in_b};
    w_prod_full = w_a_ext * w_b_ext;
    // Arithmetic right shift discards the low fraction bits (floor rounding)
    w_prod      = MULT_OUT_SIZE'($signed(w_prod_full) >>> TRIM_SHIFT);
    w_sum       = {acc_q[ACC_SIZE-1], acc_q}
                + {{(ACC_SIZE+1-MULT_OUT_SIZE){w_prod[MULT_OUT_SIZE-1]}}, w_prod};
    // Guard bit disagreeing with the result sign bit means out of range
    w_ovf       = w_sum[ACC_SIZE] ^ w_sum[ACC_SIZE-1];
    acc_d       = w_sum[ACC_SIZE-1:0];
    if (w_ovf) begin
      acc_d = w_sum[ACC_SIZE] ? ACC_MIN : ACC_MAX;
    end
    sat_d       = sat_q | w_ovf;
  end

  // Control FSM with registered handshake/status outputs and the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q  <= '0;
            sat_q  <= 1'b0;
            busy_q <= 1'b1;
            cnt_q  <= len;
            if (len != '0) begin
              state_q    <= S_RUN;
              in_ready_q <= 1'b1;
            end else begin
              // Empty vector: the result is zero and is offered immediately
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (in_valid) begin
            acc_q <= acc_d;
            sat_q <= sat_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == LEN_SIZE'(1)) begin
              state_q     <= S_DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end

        S_DONE: begin
          // Result and flag are held in acc_q/sat_q until accepted
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign out_sat   = sat_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_seq
//  Description : Self-checking bench for mac_seq. A reference model computes
//                each expected dot product as operands are driven and pushes
//                it to a scoreboard queue; results are popped and compared
//                when the DUT offers them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_seq;

  localparam int IFDATA_SIZE   = 8;
  localparam int WDATA_SIZE    = 8;
  localparam int MULT_OUT_SIZE = 8;
  localparam int ACC_SIZE      = 12;
  localparam int LEN_SIZE      = 8;
  localparam int ACC_HI        = 2047;
  localparam int ACC_LO        = -2048;

  logic                   clk;
  logic                   rst_n;
  logic                   start;
  logic [LEN_SIZE-1:0]    len;
  logic                   in_valid;
  logic                   in_ready;
  logic [IFDATA_SIZE-1:0] in_a;
  logic [WDATA_SIZE-1:0]  in_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_SIZE-1:0]    out_data;
  logic                   out_sat;
  logic                   busy;

  typedef struct {
    int data;
    int sat;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run;
  int   tests_failed;
  int   m_acc;
  int   m_sat;

  mac_seq #(
    .IFDATA_SIZE  (IFDATA_SIZE),
    .WDATA_SIZE   (WDATA_SIZE),
    .MULT_OUT_SIZE(MULT_OUT_SIZE),
    .ACC_SIZE     (ACC_SIZE),
    .LEN_SIZE     (LEN_SIZE)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dut_data();
    return int'($signed(out_data));
  endfunction

  // floor(a*b/256) computed in real arithmetic, independent of bit slicing
  function automatic int prod_model(input int a, input int b);
    real r;
    r = $floor(real'(a * b) / 256.0);
    return int'(r);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_acc = 0;
    m_sat = 0;
  endtask

  task automatic push_expected();
    exp_t e;
    e.data = m_acc;
    e.sat  = m_sat;
    sb_q.push_back(e);
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    len   = LEN_SIZE'(n);
    step();
    start = 1'b0;
    len   = '0;
    model_clear();
    if (n == 0) push_expected();
  endtask

  // Drive one pair for exactly one cycle; model accumulates with clamping
  task automatic send_pair(input int a, input int b, input string tag);
    in_a     = IFDATA_SIZE'(a);
    in_b     = WDATA_SIZE'(b);
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    m_acc = m_acc + prod_model(a, b);
    if (m_acc > ACC_HI) begin m_acc = ACC_HI; m_sat = 1; end
    if (m_acc < ACC_LO) begin m_acc = ACC_LO; m_sat = 1; end
  endtask

  // Wait (bounded) for a result, compare with scoreboard, then accept it
  task automatic collect(input string tag, input bit also_start);
    int   n;
    exp_t e;
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    if (!out_valid) begin
      chk({tag, "_out_valid_timeout"}, 0, 1);
      return;
    end
    if (sb_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 0, 1);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_out_data"}, dut_data(), e.data);
    chk({tag, "_out_sat"}, int'(out_sat), e.sat);
    out_ready = 1'b1;
    start     = also_start;
    len       = also_start ? LEN_SIZE'(3) : '0;
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    len       = '0;
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_idle_out_valid"}, int'(out_valid), 0);
    chk({tag, "_idle_in_ready"}, int'(in_ready), 0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_clear();
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_data", dut_data(), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    rst_n = 1'b1;
    step();

    // Three identical pairs back to back: 1.0 * 1.0 three times
    do_start(3);
    chk("t35_busy", int'(busy), 1);
    for (int i = 0; i < 3; i++) send_pair(128, 64, "t35");
    chk("t35_latency_out_valid", int'(out_valid), 1);
    chk("t35_in_ready_low", int'(in_ready), 0);
    push_expected();
    collect("t35", 1'b0);

    // Gap of four idle cycles between the two pairs
    do_start(2);
    send_pair(255, -128, "t36a");
    for (int i = 0; i < 4; i++) begin
      chk("t36_gap_in_ready", int'(in_ready), 1);
      chk("t36_gap_out_valid", int'(out_valid), 0);
      step();
    end
    send_pair(0, 50, "t36b");
    push_expected();
    collect("t36", 1'b0);

    // Positive saturation
    do_start(20);
    for (int i = 0; i < 20; i++) send_pair(255, 127, "t37");
    push_expected();
    collect("t37", 1'b0);

    // Empty vector, consumer stalls, start during DONE is ignored
    do_start(0);
    chk("t38_out_valid_next", int'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      chk("t38_hold_valid", int'(out_valid), 1);
      chk("t38_hold_data", dut_data(), 0);
      chk("t38_hold_sat", int'(out_sat), 0);
      step();
    end
    start = 1'b1;
    len   = LEN_SIZE'(5);
    step();
    start = 1'b0;
    len   = '0;
    chk("t38_start_ignored_valid", int'(out_valid), 1);
    chk("t38_start_ignored_in_ready", int'(in_ready), 0);
    collect("t38", 1'b1);
    chk("t38_release_busy2", int'(busy), 0);

    // Asynchronous reset mid-run, then a fresh one-pair product
    do_start(4);
    send_pair(128, 64, "t39a");
    send_pair(128, 64, "t39b");
    rst_n = 1'b0;
    #1;
    chk("t39_rst_in_ready", int'(in_ready), 0);
    chk("t39_rst_out_valid", int'(out_valid), 0);
    chk("t39_rst_busy", int'(busy), 0);
    chk("t39_rst_out_data", dut_data(), 0);
    chk("t39_rst_out_sat", int'(out_sat), 0);
    step();
    rst_n = 1'b1;
    step();
    do_start(1);
    send_pair(128, 64, "t39c");
    push_expected();
    collect("t39", 1'b0);

    // Negative single product, then return to idle
    do_start(1);
    send_pair(128, -128, "t40");
    push_expected();
    collect("t40", 1'b0);

    // Negative saturation
    do_start(20);
    for (int i = 0; i < 20; i++) send_pair(255, -128, "tneg");
    push_expected();
    collect("tneg", 1'b0);

    // Random vectors with random input gaps
    for (int v = 0; v < 6; v++) begin
      int n;
      n = int'($urandom_range(1, 8));
      do_start(n);
      for (int i = 0; i < n; i++) begin
        int gap;
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) step();
        send_pair(int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)) - 128, "trand");
      end
      push_expected();
      collect("trand", 1'b0);
    end

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute time guard so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mac_seq.md
MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 SHALL have parameter IFDATA_SIZE, default 8, ifmap operand width, unsigned fixed (8,7).
REQ-002 SHALL have parameter WDATA_SIZE, default 8, weight operand width, signed fixed (8,6).
REQ-003 SHALL have parameter MULT_OUT_SIZE, default 8, trimmed product width, signed fixed (8,5).
REQ-004 SHALL have parameter ACC_SIZE, default 12, accumulator/result width, signed, 5 fraction bits.
REQ-005 SHALL have parameter LEN_SIZE, default 8, vector-length field width.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port start  input  1  one-cycle request to begin a dot product; honoured only in IDLE.
REQ-009 SHALL have port len  input  LEN_SIZE  number of operand pairs; sampled when start is honoured.
REQ-010 SHALL have port in_valid  input  1  operand pair present.
REQ-011 SHALL have port in_ready  output  1  block accepts an operand pair this cycle.
REQ-012 SHALL have port in_a  input  IFDATA_SIZE  ifmap operand.
REQ-013 SHALL have port in_b  input  WDATA_SIZE  weight operand.
REQ-014 SHALL have port out_valid  output  1  result available.
REQ-015 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-016 SHALL have port out_data  output  ACC_SIZE  accumulated dot product.
REQ-017 SHALL have port out_sat  output  1  accumulator saturated at least once during this dot product.
REQ-018 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-019 SHALL implement states IDLE, RUN, DONE.
REQ-020 IDLE: start=1 with len>0 -> RUN, remaining count loaded with len, accumulator and sat flag cleared.
REQ-021 IDLE: start=1 with len=0 -> DONE directly, accumulator=0, sat=0.
REQ-022 start SHALL be ignored in RUN and DONE.
REQ-023 in_ready SHALL equal 1 exactly in RUN; a pair is consumed on cycles with in_valid && in_ready.
REQ-024 product SHALL be bits [15:8] of the 16-bit signed product of zero-extended in_a and signed in_b, i.e. floor(a*b/256), range -128..126.
REQ-025 On each consumed pair, accumulator SHALL update to sat(acc + sign-extended product), clamped to [-2^(ACC_SIZE-1), 2^(ACC_SIZE-1)-1].
REQ-026 Any clamping event SHALL set the sticky sat flag, held until the next honoured start.
REQ-027 Remaining count SHALL decrement per consumed pair; the pair taking it from 1 to 0 moves RUN -> DONE on the same edge.
REQ-028 Cycles in RUN with in_valid=0 SHALL leave accumulator and count unchanged.
REQ-029 out_valid SHALL equal 1 exactly in DONE; out_data/out_sat SHALL hold the final accumulator and sat flag, stable while out_valid && !out_ready.
REQ-030 DONE with out_ready=1 -> IDLE on the next edge; no new start accepted in that same cycle.
REQ-031 Latency: out_valid SHALL rise on the cycle after the last pair is consumed.
REQ-032 The multiply/accumulate path SHALL be single-cycle combinational into the accumulator register.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, accumulator=0, count=0, sat=0, in_ready=0, out_valid=0, out_data=0, out_sat=0, busy=0, including mid-RUN or mid-DONE.
REQ-034 After rst_n deasserts, the first honoured start SHALL behave as REQ-020/021.

Verification
REQ-035 start, len=3; pairs (128,64) x3 back-to-back -> in_ready high 3 cycles, out_valid next cycle, out_data=96 (3.0), out_sat=0.
REQ-036 start, len=2; pair (255,-128) then (0,50), in_valid gap of 4 cycles between -> out_data=-128, accumulator unchanged during gap.
REQ-037 start, len=20; (255,127) each -> product 126, sum 2520 clamps: out_data=2047, out_sat=1.
REQ-038 start, len=0 -> out_valid next cycle, out_data=0; hold out_ready=0 5 cycles -> outputs stable; pulse start during DONE -> ignored.
REQ-039 start, len=4; assert rst_n=0 after 2 pairs -> all outputs zero immediately; new start len=1 with (128,64) -> out_data=32.
REQ-040 start, len=1, (128,-128) -> out_data=-64 (-2.0); out_ready=1 -> IDLE next cycle, busy=0.
